pipemem_io: RTL and testbench
=============================

# pipemem_io

Parametrised MEM-stage block for the pipelined CPU: word-addressed data RAM plus a memory-mapped I/O window with N_IN input ports, N_OUT output registers and a read-to-clear change-status word. It sits between the EX/MEM and MEM/WB pipeline registers. It runs on the single CPU clock, so it needs no inverted memory clock. Generalises the two-input/four-output MEM stage with configurable widths, counts and input synchronisation.

## Interface
- DATA_W, 32, data/address width
- DEPTH, 32, data RAM words (power of 2, 2..1024)
- N_IN, 2, input ports (1..7)
- N_OUT, 4, output ports (1..8)
- IO_BIT, 7, address bit selecting I/O window (must be ≥ log2(DEPTH)+2)
- clock  in  1  CPU clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- mwmem  in  1  store in MEM stage
- mrmem  in  1  load in MEM stage (qualifies read side effects)
- malu  in  DATA_W  byte address from ALU
- mb  in  DATA_W  store data
- in_port  in  N_IN*DATA_W  external inputs, port i at [i*DATA_W +: DATA_W]
- mmo  out  DATA_W  load data to MEM/WB
- out_port  out  N_OUT*DATA_W  output registers, same packing

## Operation
- Decode: io_sel = malu[IO_BIT]. RAM index = malu[log2(DEPTH)+1:2]. I/O word index = malu[5:2].
- RAM: asynchronous read, write at edge when mwmem & ~io_sel. Contents are not reset.
- I/O map, reads:
  - word 0 reads the status word: bits [N_IN-1:0] are the change flags, the rest are 0.
  - words 1..N_IN read synchronised input port index-1.
  - words 8..8+N_OUT-1 read back out_port index-8.
  - all other words read 0.
- I/O writes:
  - writes to words 8..8+N_OUT-1 load the matching out_port register from mb.
  - writes to all other I/O words are ignored.
- mmo = io_sel ? I/O read mux : RAM read. This is combinational from malu, independent of mrmem.
- Change flag i:
  - set when the synchronised value of port i changes.
  - cleared at the edge where mrmem & io_sel & word==0.
  - if set and clear occur in the same cycle, set wins, so no event is lost.
- mwmem & mrmem both high: treated as store, no flag clear.
- Reset values: out_port all 0, flags 0, sync stages 0, mmo follows the decode of current inputs.

## Timing
- Load: mmo valid in the same cycle malu is presented (zero-cycle, as required by the MEM stage).
- Store: RAM/out_port update at the edge ending the MEM cycle. A load to the same address in the next cycle returns the new value.
- Input latency with sync enabled: in_port stable before edge k → sync0 at k, visible value and flag update at edge k+1.
- Input latency with sync disabled: visible value and flag update at edge k.
- Reset asserted mid-operation: a store in the same cycle is dropped for out_port, flags and syncs. A RAM write in that cycle is also suppressed.

## Configuration
- PIPEMEM_IO_SYNC_EN defined: two flop stages per input port (metastability synchroniser). The change compare is stage0 ≠ stage1.
- Undefined: single register stage. The change compare is in_port ≠ stage. This saves N_IN*DATA_W flops and one cycle of latency.
- Map, flag semantics and reset behaviour are identical in both builds.

## Structure
- Shared package pipemem_io_pkg holds:
  - I/O word index constants: STATUS_WORD=0, IN_BASE=1, OUT_BASE=8.
  - index width constant.
  - function clog2 for RAM index width.
- One natural sub-module, pipemem_io_inport: one port's synchroniser, change detect and read-to-clear flag. It is instantiated N_IN times via generate.
- RAM is inferred inline: distributed/async read array.

## Test plan
- Reset, then load from 0x80, 0xA0, 0xBC → mmo=0 in each case, and out_port=0.
- Store 0xDEADBEEF to 0x14, then load from 0x14 next cycle → mmo=0xDEADBEEF. A load from 0x94 (I/O alias) does not return it.
- Store 0x12345678 to 0xA4 → out_port[1] updates after the edge, and a readback from 0xA4 gives 0x12345678. A store to 0x84 changes nothing.
- in_port[0] driven 0→0x55 before edge k:
  - with PIPEMEM_IO_SYNC_EN, a load from 0x84 returns 0x55 and a load from 0x80 returns 0x1 from k+1. Without the macro, the same values appear from edge k.
- Flag read-to-clear:
  - load 0x80 with mrmem=1 → next-cycle status reads 0.
  - if in_port[1] changes so that its flag sets in that same clear cycle, the status reads 0x2 afterwards.
- Assert reset during a store to 0xA0 → out_port[0] stays 0 and all flags are 0 afterwards.

Source files
------------

// File: rtl/pipemem_io_pkg.sv
// rtl/pipemem_io_pkg.sv - shared I/O map constants and helpers for pipemem_io
package pipemem_io_pkg;

    localparam int IDX_W       = 4;
    localparam int STATUS_WORD = 0;
    localparam int IN_BASE     = 1;
    localparam int OUT_BASE    = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipemem_io_inport.sv
// rtl/pipemem_io_inport.sv - one input port: synchroniser, change detect, read-to-clear flag
// PIPEMEM_IO_SYNC_EN selects a two-flop synchroniser; otherwise a single register stage.
module pipemem_io_inport #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              clr,
    output logic [DATA_W-1:0] dout,
    output logic              flag
);

    logic change;
    logic flag_q;
    logic flag_d;

`ifdef PIPEMEM_IO_SYNC_EN
    logic [DATA_W-1:0] s0_q;
    logic [DATA_W-1:0] s0_d;
    logic [DATA_W-1:0] s1_q;
    logic [DATA_W-1:0] s1_d;

    always_comb begin
        s0_d   = din;
        s1_d   = s0_q;
        change = (s0_q != s1_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    assign dout = s1_q;
`else
    logic [DATA_W-1:0] stage_q;
    logic [DATA_W-1:0] stage_d;

    always_comb begin
        stage_d = din;
        change  = (din != stage_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q;
`endif

    // A change landing in the clearing cycle keeps the flag set so no event is lost.
    always_comb begin
        flag_d = change | (flag_q & ~clr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/pipemem_io.sv
// rtl/pipemem_io.sv - MEM stage: async-read data RAM plus memory-mapped I/O window
// PIPEMEM_IO_SYNC_EN enables two-flop input synchronisers in every pipemem_io_inport.
module pipemem_io
    import pipemem_io_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 4,
    parameter int IO_BIT = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mwmem,
    input  logic                    mrmem,
    input  logic [DATA_W-1:0]       malu,
    input  logic [DATA_W-1:0]       mb,
    input  logic [N_IN*DATA_W-1:0]  in_port,
    output logic [DATA_W-1:0]       mmo,
    output logic [N_OUT*DATA_W-1:0] out_port
);

    localparam int AW = clog2(DEPTH);

    logic              io_sel;
    logic [IDX_W-1:0]  word;
    logic [AW-1:0]     ram_idx;
    logic              ram_we;
    logic              io_clr;
    logic [DATA_W-1:0] io_rd;
    logic [N_IN-1:0]   flag;
    logic [DATA_W-1:0] in_vis [N_IN];
    logic [DATA_W-1:0] out_q  [N_OUT];
    logic [DATA_W-1:0] out_d  [N_OUT];
    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic              unused_malu;

    assign io_sel      = malu[IO_BIT];
    assign word        = malu[IDX_W+1:2];
    assign ram_idx     = malu[AW+1:2];
    assign unused_malu = ^malu;

    // Reset blocks RAM writes as well, so a store caught by reset has no effect anywhere.
    assign ram_we = mwmem & ~io_sel & ~reset;
    // A simultaneous store wins over the load, so it must not clear status.
    assign io_clr = mrmem & ~mwmem & io_sel & (word == IDX_W'(STATUS_WORD));

    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem_q[ram_idx] <= mb;
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        pipemem_io_inport #(
            .DATA_W(DATA_W)
        ) u_inport (
            .clock (clock),
            .reset (reset),
            .din   (in_port[g*DATA_W +: DATA_W]),
            .clr   (io_clr),
            .dout  (in_vis[g]),
            .flag  (flag[g])
        );
    end

    always_comb begin
        out_d = out_q;
        if (mwmem & io_sel) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (word == IDX_W'(OUT_BASE + i)) begin
                    out_d[i] = mb;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_OUT; i++) begin
            if (reset) begin
                out_q[i] <= '0;
            end else begin
                out_q[i] <= out_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_port[g*DATA_W +: DATA_W] = out_q[g];
    end

    always_comb begin
        io_rd = '0;
        if (word == IDX_W'(STATUS_WORD)) begin
            io_rd[N_IN-1:0] = flag;
        end
        for (int i = 0; i < N_IN; i++) begin
            if (word == IDX_W'(IN_BASE + i)) begin
                io_rd = in_vis[i];
            end
        end
        for (int i = 0; i < N_OUT; i++) begin
            if (word == IDX_W'(OUT_BASE + i)) begin
                io_rd = out_q[i];
            end
        end
    end

    assign mmo = io_sel ? io_rd : mem_q[ram_idx];

endmodule

// File: tb/tb_pipemem_io.sv
// tb/tb_pipemem_io.sv - directed bench with behavioural reference model for pipemem_io
module tb_pipemem_io;

`ifdef PIPEMEM_IO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        mwmem;
    logic        mrmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [63:0] in_port;
    logic [31:0] mmo;
    logic [127:0] out_port;

    pipemem_io #(
        .DATA_W(32), .DEPTH(32), .N_IN(2), .N_OUT(4), .IO_BIT(7)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mwmem    (mwmem),
        .mrmem    (mrmem),
        .malu     (malu),
        .mb       (mb),
        .in_port  (in_port),
        .mmo      (mmo),
        .out_port (out_port)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    bit started = 0;

    logic [31:0] ram_m [int];
    logic [31:0] out_m [4];
    logic [31:0] vis_m [2];
    logic [31:0] seen_m [2];
    logic [1:0]  flag_m;

    logic        rst_next;
    logic [31:0] in_next [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a port's visible value is what it held LAT edges earlier;
    // its flag rises whenever that visible value moves.
    always @(posedge clock) begin
        logic [31:0] cur;
        logic [31:0] nv;
        logic        clr;
        int          w;
        if (reset) begin
            for (int i = 0; i < 4; i++) out_m[i] = '0;
            for (int i = 0; i < 2; i++) begin
                vis_m[i]  = '0;
                seen_m[i] = '0;
            end
            flag_m = '0;
        end else begin
            w = int'(malu[5:2]);
            if (mwmem && !malu[7]) ram_m[int'(malu[6:2])] = mb;
            if (mwmem && malu[7] && w >= 8 && w < 12) out_m[w-8] = mb;
            clr = mrmem && !mwmem && malu[7] && (w == 0);
            for (int i = 0; i < 2; i++) begin
                cur = in_port[i*32 +: 32];
                nv  = (LAT == 2) ? seen_m[i] : cur;
                flag_m[i] = (nv != vis_m[i]) || (flag_m[i] && !clr);
                vis_m[i]  = nv;
                seen_m[i] = cur;
            end
        end
    end

    always @(negedge clock) begin
        logic [31:0] exp;
        bit          known;
        int          w;
        if (started) begin
            for (int i = 0; i < 4; i++) chk("model out_port", out_port[i*32 +: 32], out_m[i]);
            w     = int'(malu[5:2]);
            known = 1;
            exp   = '0;
            if (!malu[7]) begin
                if (ram_m.exists(int'(malu[6:2]))) exp = ram_m[int'(malu[6:2])];
                else known = 0;
            end else if (w == 0) begin
                exp = {30'b0, flag_m};
            end else if (w >= 1 && w <= 2) begin
                exp = vis_m[w-1];
            end else if (w >= 8 && w < 12) begin
                exp = out_m[w-8];
            end
            if (known) chk("model mmo", mmo, exp);
        end
    end

    task automatic apply(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(posedge clock);
        #1;
        reset   = rst_next;
        mwmem   = w;
        mrmem   = r;
        malu    = a;
        mb      = d;
        in_port = {in_next[1], in_next[0]};
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; mwmem = 0; mrmem = 0; malu = '0; mb = '0; in_port = '0;
        rst_next = 1'b1;
        in_next[0] = '0;
        in_next[1] = '0;
        repeat (2) @(posedge clock);
        #1 started = 1;
        rst_next = 1'b0;

        apply(0, 1, 32'h80, 0); chk("status after reset", mmo, 32'h0);
        apply(0, 1, 32'hA0, 0); chk("out0 after reset", mmo, 32'h0);
        apply(0, 1, 32'hBC, 0); chk("unmapped 0xBC", mmo, 32'h0);
        chk("out_port after reset", out_port[31:0] | out_port[63:32] | out_port[95:64] | out_port[127:96], 32'h0);

        apply(1, 0, 32'h14, 32'hDEADBEEF);
        apply(0, 1, 32'h14, 0); chk("ram readback", mmo, 32'hDEADBEEF);
        apply(0, 1, 32'h94, 0); chk("io alias 0x94", mmo, 32'h0);

        apply(1, 0, 32'hA4, 32'h12345678); chk("out1 before edge", out_port[63:32], 32'h0);
        apply(0, 1, 32'hA4, 0); chk("out1 readback", mmo, 32'h12345678);
        chk("out_port[1]", out_port[63:32], 32'h12345678);
        apply(1, 0, 32'h84, 32'hFFFFFFFF);
        apply(0, 0, 32'h84, 0); chk("store to input ignored", mmo, 32'h0);

        in_next[0] = 32'h55;
        apply(0, 0, 32'h84, 0); chk("in0 before edge k", mmo, 32'h0);
        apply(0, 0, 32'h80, 0); chk("status after edge k", mmo, (LAT == 1) ? 32'h1 : 32'h0);
        apply(0, 0, 32'h84, 0); chk("in0 after k+1", mmo, 32'h55);
        apply(0, 0, 32'h80, 0); chk("status after k+1", mmo, 32'h1);

        apply(0, 1, 32'h80, 0); chk("status clearing read", mmo, 32'h1);
        apply(0, 0, 32'h80, 0); chk("status cleared", mmo, 32'h0);

        if (LAT == 2) in_next[1] = 32'h7;
        apply(0, 0, 32'h14, 0);
        in_next[1] = 32'h7;
        apply(0, 1, 32'h80, 0); chk("status in clear cycle", mmo, 32'h0);
        apply(0, 0, 32'h80, 0); chk("set wins over clear", mmo, 32'h2);
        apply(1, 1, 32'h80, 0);
        apply(0, 0, 32'h80, 0); chk("store+load no clear", mmo, 32'h2);
        apply(0, 0, 32'h88, 0); chk("in1 readback", mmo, 32'h7);

        apply(1, 0, 32'hAC, 32'hA5A5A5A5);
        apply(1, 0, 32'hB0, 32'hFFFFFFFF);
        apply(0, 0, 32'hAC, 0); chk("last out port", mmo, 32'hA5A5A5A5);
        chk("out_port[3]", out_port[127:96], 32'hA5A5A5A5);
        apply(0, 0, 32'hB0, 0); chk("beyond last out port", mmo, 32'h0);

        rst_next = 1'b1;
        apply(1, 0, 32'h14, 32'h11111111);
        apply(1, 0, 32'hA0, 32'hCAFE0000);
        rst_next = 1'b0;
        apply(0, 0, 32'h80, 0); chk("flags after reset store", mmo, 32'h0);
        chk("out_port[0] after reset store", out_port[31:0], 32'h0);
        chk("out_port[3] cleared by reset", out_port[127:96], 32'h0);
        apply(0, 0, 32'hA0, 0); chk("out0 readback after reset", mmo, 32'h0);
        apply(0, 0, 32'h14, 0); chk("ram write under reset dropped", mmo, 32'hDEADBEEF);

        apply(0, 0, 32'h84, 0);
        apply(0, 0, 32'h84, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
